axi_read_responder: RTL



---
 rtl/axi_read_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// AXI-style read responder: in-order request FIFO feeding a latency/burst engine over a preloadable word array.
// Optional build macro AXI_RESP_WRAP_EN: bursts wrap inside their aligned (arlen+1)-word block.
module axi_read_responder #(
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 4,
  parameter int REQ_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [3:0]                arlen,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [ID_WIDTH-1:0]       rid,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic                      ld_en,
  input  logic [MEM_WORDS_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data
);
  localparam int PW = $clog2(REQ_DEPTH);

  typedef logic [MEM_WORDS_LOG2-1:0] word_t;
  typedef struct packed {
    word_t               addr;
    logic [3:0]          len;
    logic [ID_WIDTH-1:0] id;
  } req_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];
  req_t                  fifo_mem [REQ_DEPTH];

  state_t                state_q, state_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]            cnt_q, cnt_d, beat_q, beat_d, len_q, len_d;
  word_t                 base_q, base_d;
  logic [ID_WIDTH-1:0]   id_q, id_d, rid_q, rid_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  fifo_full, fifo_empty, push, pop, rd_en;
  logic [3:0]            rd_beat;
  word_t                 rd_word, wrap_mask;
  req_t                  head;
  logic                  unused_addr;

  assign unused_addr = ^{araddr[1:0], araddr[ADDR_WIDTH-1:2+MEM_WORDS_LOG2]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign arready    = ~fifo_full;
  assign push       = arvalid & arready;
  assign head       = fifo_mem[rd_ptr_q[PW-1:0]];

  // An all-ones mask degenerates the wrap formula into plain base+beat (modulo array size).
`ifdef AXI_RESP_WRAP_EN
  assign wrap_mask = word_t'(len_q);
`else
  assign wrap_mask = '1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    base_d   = base_q;
    len_d    = len_q;
    id_d     = id_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    pop      = 1'b0;
    rd_en    = 1'b0;
    rd_beat  = beat_q;
    rd_word  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          rd_en    = 1'b1;
          rd_beat  = 4'd0;
          beat_d   = 4'd0;
          rvalid_d = 1'b1;
          rlast_d  = (len_q == 4'd0);
          rid_d    = id_q;
          cnt_d    = 4'd0;
          state_d  = S_BURST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            rd_en   = 1'b1;
            rd_beat = beat_q + 4'd1;
            beat_d  = beat_q + 4'd1;
            rlast_d = ((beat_q + 4'd1) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      base_d = head.addr;
      len_d  = head.len;
      id_d   = head.id;
      cnt_d  = 4'(LATENCY);
    end
    rd_word = (base_q & ~wrap_mask) | ((base_q + word_t'(rd_beat)) & wrap_mask);
    // Array is written at the edge, so this read sees pre-write contents.
    if (rd_en) rdata_d = mem[rd_word];
  end

  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (push)  fifo_mem[wr_ptr_q[PW-1:0]] <= {araddr[2 +: MEM_WORDS_LOG2], arlen, arid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      base_q   <= '0;
      id_q     <= '0;
      rid_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      base_q   <= base_d;
      id_q     <= id_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;
endmodule
